cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
Instruction fetch stage directly upstream of cpu_control_unit. Maintains the fetch PC and issues in-order requests to instruction memory over a valid/ready request and valid-only response interface. Buffers returned words in a small FIFO and presents one instruction at a time, pre-split into opcode/funct3/funct7/rs1/rs2/rd fields, with a valid/ready handshake. Supports PC redirect from branch/jump resolution, which flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded at reset
DEPTH, 2, instruction buffer entries; in-flight plus buffered words never exceed DEPTH (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-high (rst_n=1 resets)
o_imem_req_valid  output  1  fetch request valid
i_imem_req_ready  input  1  memory accepts request
o_imem_addr  output  32  fetch address, word aligned in normal operation
i_imem_rsp_valid  input  1  response word valid; responses return in request order, latency >=1 cycle
i_imem_rsp_data  input  32  response instruction word
i_redirect_valid  input  1  redirect fetch to i_redirect_pc
i_redirect_pc  input  32  redirect target
o_instr_valid  output  1  buffer head valid toward control unit
i_instr_ready  input  1  control unit consumes head
o_instr  output  32  head instruction word
o_pc  output  32  PC of head instruction
o_opcode  output  7  o_instr[6:0]
o_funct3  output  3  o_instr[14:12]
o_funct7  output  7  o_instr[31:25]
o_rs1  output  5  o_instr[19:15]
o_rs2  output  5  o_instr[24:20]
o_rd  output  5  o_instr[11:7]
o_misaligned  output  1  misaligned-redirect flag (tied 0 when feature off)

Behaviour:
- Reset: fetch PC=RESET_PC, buffer empty, inflight=0, discard=0, state=IDLE; o_imem_req_valid=0, o_instr_valid=0, o_instr=0, o_pc=0, all field outputs 0, o_misaligned=0.
- States: IDLE -> RUN unconditionally next cycle after reset deasserts; RUN stays; HALT only with optional feature.
- RUN: o_imem_req_valid=1 when inflight+count < DEPTH and not redirecting this cycle; o_imem_addr=fetch PC. On req handshake: inflight+1, push PC to a DEPTH-deep pending-PC queue, fetch PC += 4 (wraps mod 2^32).
- Response: if discard>0, drop word, discard-1, inflight-1. Else write {data, pending PC} to buffer tail, inflight-1. Buffer never overflows by construction.
- Output: o_instr_valid = count>0; fields are combinational slices of head word; pop on o_instr_valid & i_instr_ready. Empty buffer: fields hold 0.
- Same-cycle push and pop: both apply, count unchanged; push into empty buffer is visible next cycle (latency request->o_instr_valid = memory latency + 1).
- Redirect (priority over everything): next cycle buffer empty, pending-PC queue cleared, fetch PC=i_redirect_pc, discard = inflight after this cycle's response/request updates (a request accepted in the redirect cycle is not allowed since req_valid=0; a response arriving in the redirect cycle is dropped). Pop in redirect cycle is honoured by consumer but buffer still flushed.
- Redirect while discard>0: discard accumulates; no stale word ever reaches o_instr.
- rst_n mid-operation: all state returns to reset values next edge; responses to pre-reset requests arriving after reset are not tracked (system resets memory together).

Optional Feature:
FETCH_MISALIGN_CHECK_EN: defined -> redirect with i_redirect_pc[1:0]!=0 sets o_misaligned=1 (sticky until reset), flushes as a normal redirect, enters HALT: no further requests, in-flight responses discarded, o_instr_valid=0. Undefined -> o_misaligned tied 0, i_redirect_pc[1:0] ignored (fetch address forced to {pc[31:2],2'b00}), no HALT state.

Test Plan:
- Reset, memory ready=1, 1-cycle latency, consumer ready=1 -> addresses 0x0,0x4,0x8 issued back to back; o_pc sequence 0x0,0x4,0x8 with o_instr matching returned words.
- Return 0x00A28293 (addi x5,x5,10) -> o_opcode=0x13, o_rd=5, o_funct3=0, o_rs1=5, o_rs2=0x0A, o_funct7=0.
- Consumer ready=0 for 10 cycles -> exactly DEPTH=2 requests issued, then req_valid=0; release -> words delivered in order, no loss.
- Redirect to 0x100 with 2 requests in flight -> both old responses dropped, next o_pc=0x100, next address 0x100.
- Memory ready toggled 0/1 and latency 3 cycles -> ordering and PC pairing preserved, no duplicate fetch.
- Feature on, redirect to 0x102 -> o_misaligned=1 next cycle, req_valid stays 0, o_instr_valid=0 until reset.

Source files
------------

// File: rtl/cpu_fetch_if.sv
// ---------------------------------------------------------------------------
// cpu_fetch_if
// Bundles every signal of cpu_fetch_unit except clk and rst_n: the
// instruction-memory request/response channel, the redirect input and the
// decoded instruction output toward the control unit.
//   master : the fetch unit (drives o_* signals, samples i_* signals)
//   slave  : the environment (memory + redirect source + control unit)
// ---------------------------------------------------------------------------
interface cpu_fetch_if;
    // Instruction-memory request (valid/ready) and response (valid only)
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    // Redirect from branch/jump resolution
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    // Instruction toward the control unit (valid/ready)
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [4:0]  o_rd;
    logic        o_misaligned;

    modport master (
        output o_imem_req_valid, o_imem_addr,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        input  i_redirect_valid, i_redirect_pc,
        output o_instr_valid, o_instr, o_pc,
        output o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd,
        output o_misaligned,
        input  i_instr_ready
    );

    modport slave (
        input  o_imem_req_valid, o_imem_addr,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        output i_redirect_valid, i_redirect_pc,
        input  o_instr_valid, o_instr, o_pc,
        input  o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd,
        input  o_misaligned,
        output i_instr_ready
    );
endinterface

// File: rtl/cpu_fetch_unit.sv
// ---------------------------------------------------------------------------
// cpu_fetch_unit
// Instruction fetch stage. Keeps the fetch PC, issues in-order requests to
// instruction memory, buffers returned words in a DEPTH-entry FIFO and hands
// one pre-decoded instruction at a time to the control unit. A redirect
// flushes the buffer and marks every in-flight response for discard.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous reset, active HIGH despite the name (1 = reset)
//   bus   - cpu_fetch_if.master: imem request/response, redirect, and the
//           instruction/PC/field outputs
//
// Parameters:
//   RESET_PC - fetch PC after reset
//   DEPTH    - buffer entries; in-flight plus buffered words never exceed it
//              (power of 2, >= 2)
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a non-word-aligned
//   target raises a sticky o_misaligned and parks the unit in HALT until
//   reset. When undefined, o_misaligned is 0 and the two low target bits are
//   dropped.
// ---------------------------------------------------------------------------
module cpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic         clk,
    input logic         rst_n,
    cpu_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t          CNT_ONE   = cnt_t'(1);
    localparam ptr_t          PTR_ONE   = ptr_t'(1);
    localparam logic [CW:0]   OCC_LIMIT = (CW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t      state, state_next;
    logic [31:0] fetch_pc;
    cnt_t        inflight, inflight_next;
    cnt_t        discard;
    cnt_t        count;
    ptr_t        buf_rd, buf_wr;
    ptr_t        pq_rd, pq_wr;

    // Word buffer and the queue of PCs belonging to live (non-discarded)
    // requests, matched to responses in order.
    logic [31:0] buf_data [DEPTH];
    logic [31:0] buf_pc   [DEPTH];
    logic [31:0] pq_pc    [DEPTH];

    logic        redirect;
    logic [31:0] redirect_target;
    logic        bad_target;
    logic [CW:0] occupancy;
    logic        req_valid, req_fire;
    logic        rsp_take, push, pop;
    logic        head_valid;
    logic [31:0] head_instr, head_pc;

    assign redirect = bus.i_redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    assign redirect_target = bus.i_redirect_pc;
    assign bad_target      = redirect && (bus.i_redirect_pc[1:0] != 2'b00);
    assign bus.o_misaligned = misaligned;
`else
    logic unused_redirect_lsbs;
    assign redirect_target      = {bus.i_redirect_pc[31:2], 2'b00};
    assign bad_target           = 1'b0;
    assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];
    assign bus.o_misaligned     = 1'b0;
`endif

    // Request only while credits remain; a redirect cycle never requests so
    // the old fetch PC can not leak a stale request.
    assign occupancy = {1'b0, inflight} + {1'b0, count};
    assign req_valid = (state == RUN) && !redirect && (occupancy < OCC_LIMIT);
    assign req_fire  = req_valid && bus.i_imem_req_ready;

    // Responses with nothing outstanding belong to pre-reset requests.
    assign rsp_take   = bus.i_imem_rsp_valid && (inflight != '0);
    assign push       = rsp_take && (discard == '0) && !redirect;
    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.i_instr_ready;

    assign head_instr = head_valid ? buf_data[buf_rd] : 32'h0;
    assign head_pc    = head_valid ? buf_pc[buf_rd]   : 32'h0;

    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_imem_addr      = fetch_pc;
    assign bus.o_instr_valid    = head_valid;
    assign bus.o_instr          = head_instr;
    assign bus.o_pc             = head_pc;
    assign bus.o_opcode         = head_instr[6:0];
    assign bus.o_rd             = head_instr[11:7];
    assign bus.o_funct3         = head_instr[14:12];
    assign bus.o_rs1            = head_instr[19:15];
    assign bus.o_rs2            = head_instr[24:20];
    assign bus.o_funct7         = head_instr[31:25];

    // NOTE: every signal assigned in always_comb gets a default on the first
    // line, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
            HALT:    state_next = HALT;
`endif
            default: state_next = IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (bad_target) state_next = HALT;
`endif
    end

    always_comb begin
        inflight_next = inflight;
        if (req_fire) inflight_next = inflight_next + CNT_ONE;
        if (rsp_take) inflight_next = inflight_next - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            pq_rd    <= '0;
            pq_wr    <= '0;
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            if (redirect) begin
                // Everything still outstanding after this cycle is stale;
                // this also absorbs any discard count already pending.
                fetch_pc <= redirect_target;
                discard  <= inflight_next;
                count    <= '0;
                buf_rd   <= '0;
                buf_wr   <= '0;
                pq_rd    <= '0;
                pq_wr    <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    pq_wr    <= pq_wr + PTR_ONE;
                end
                if (rsp_take && (discard != '0)) discard <= discard - CNT_ONE;
                if (push) begin
                    buf_wr <= buf_wr + PTR_ONE;
                    pq_rd  <= pq_rd + PTR_ONE;
                end
                if (pop) buf_rd <= buf_rd + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst_n)           misaligned <= 1'b0;
        else if (bad_target) misaligned <= 1'b1;
    end
`endif

    // NOTE: storage arrays are not reset; the count and pointers decide what
    // is valid, so their contents never matter until written.
    always_ff @(posedge clk) begin
        if (req_fire) pq_pc[pq_wr] <= fetch_pc;
        if (push) begin
            buf_data[buf_wr] <= bus.i_imem_rsp_data;
            buf_pc[buf_wr]   <= pq_pc[pq_rd];
        end
    end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
module tb_cpu_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cpu_fetch_if bus ();

    cpu_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Decode vectors: instruction word and hand-decoded fields.
    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } cap_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          mem_toggle = 1'b0;
    vec_t        vt [5];
    logic [31:0] prog [8];
    mreq_t       mq [$];
    cap_t        cap [$];
    logic [31:0] issued_q [$];
    logic [31:0] exp_issue = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    bit          fire_req, fire_rsp;
    logic [31:0] fire_addr;

    // Memory contents: a decode program at 0x200, an address-tagged word elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h200 && a < 32'h220) return prog[a[4:2]];
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] fetch_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Observation and memory response drive, away from the active edge.
    always @(negedge clk) begin
        fire_req = 1'b0;
        fire_rsp = 1'b0;
        if (!rst_n) begin
            if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
                check("issue_addr", bus.o_imem_addr, exp_issue);
                issued_q.push_back(bus.o_imem_addr);
                fire_req  = 1'b1;
                fire_addr = bus.o_imem_addr;
            end
            if (bus.o_instr_valid && bus.i_instr_ready) begin
                check("deliver_pc", bus.o_pc, exp_pc);
                check("deliver_instr", bus.o_instr, mem_word(exp_pc));
                cap.push_back('{bus.o_pc, bus.o_instr, bus.o_opcode, bus.o_funct3,
                                bus.o_funct7, bus.o_rs1, bus.o_rs2, bus.o_rd});
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.i_imem_rsp_valid = 1'b1;
                bus.i_imem_rsp_data  = mem_word(mq[0].addr);
                fire_rsp = 1'b1;
            end else begin
                bus.i_imem_rsp_valid = 1'b0;
                bus.i_imem_rsp_data  = 32'h0;
            end
        end else begin
            bus.i_imem_rsp_valid = 1'b0;
            bus.i_imem_rsp_data  = 32'h0;
        end
    end

    // Memory model and expected-sequence bookkeeping at the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            mq.delete();
            exp_issue = RESET_PC;
            exp_pc    = RESET_PC;
        end else begin
            if (fire_rsp) void'(mq.pop_front());
            if (fire_req) begin
                mq.push_back('{fire_addr, cyc + lat - 1});
                exp_issue = exp_issue + 32'd4;
            end
            if (bus.o_instr_valid && bus.i_instr_ready) exp_pc = exp_pc + 32'd4;
            if (bus.i_redirect_valid) begin
                exp_issue = fetch_target(bus.i_redirect_pc);
                exp_pc    = fetch_target(bus.i_redirect_pc);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (mem_toggle) bus.i_imem_req_ready = ((cyc % 2) == 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = t;
        tick(1);
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'h0;
    endtask

    task automatic wait_cap(input int n, input int budget, input string name);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(cap.size() >= n), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(bus.o_imem_req_valid), 32'd0);
        check({tag, "_instr_valid"}, 32'(bus.o_instr_valid), 32'd0);
        check({tag, "_instr"}, bus.o_instr, 32'h0);
        check({tag, "_pc"}, bus.o_pc, 32'h0);
        check({tag, "_fields"}, {bus.o_opcode, bus.o_funct3, bus.o_funct7,
                                 bus.o_rs1, bus.o_rs2[4:0]}, 32'h0);
        check({tag, "_misaligned"}, 32'(bus.o_misaligned), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h00A28293, 7'h13, 3'd0, 7'h00, 5'd5,  5'd10, 5'd5};
        vt[1] = '{32'h40B50533, 7'h33, 3'd0, 7'h20, 5'd10, 5'd11, 5'd10};
        vt[2] = '{32'h0042A303, 7'h03, 3'd2, 7'h00, 5'd5,  5'd4,  5'd6};
        vt[3] = '{32'hFFFFFFFF, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31};
        vt[4] = '{32'h00000000, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0};
        for (int i = 0; i < 8; i++) prog[i] = (i < 5) ? vt[i].word : 32'h0000_0013;

        bus.i_imem_req_ready = 1'b1;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'h0;
        bus.i_instr_ready    = 1'b1;

        // Reset state, then IDLE for one cycle, then RUN requesting RESET_PC.
        tick(2);
        check_zero_outputs("reset");
        rst_n = 1'b0;
        check("idle_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        tick(1);
        check("run_req_valid", 32'(bus.o_imem_req_valid), 32'd1);
        check("run_addr", bus.o_imem_addr, RESET_PC);

        // Straight-line fetch with 1-cycle memory.
        wait_cap(3, 50, "basic_timeout");
        for (int i = 0; i < 3; i++) begin
            check("basic_pc", cap[i].pc, 32'(4 * i));
            check("basic_issue", issued_q[i], 32'(4 * i));
        end

        // Table-driven decode of the program at 0x200.
        redirect_to(32'h200);
        cap.delete();
        wait_cap(5, 100, "decode_timeout");
        for (int i = 0; i < 5; i++) begin
            check("decode_pc", cap[i].pc, 32'h200 + 32'(4 * i));
            check("decode_instr", cap[i].instr, vt[i].word);
            check("decode_opcode", 32'(cap[i].op), 32'(vt[i].op));
            check("decode_funct3", 32'(cap[i].f3), 32'(vt[i].f3));
            check("decode_funct7", 32'(cap[i].f7), 32'(vt[i].f7));
            check("decode_rs1", 32'(cap[i].rs1), 32'(vt[i].rs1));
            check("decode_rs2", 32'(cap[i].rs2), 32'(vt[i].rs2));
            check("decode_rd", 32'(cap[i].rd), 32'(vt[i].rd));
        end

        // Consumer stalled: exactly DEPTH requests, then back-pressure.
        bus.i_instr_ready = 1'b0;
        rst_n = 1'b1;
        tick(2);
        rst_n = 1'b0;
        issued_q.delete();
        tick(10);
        check("stall_issued", 32'(issued_q.size()), 32'(DEPTH));
        check("stall_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(bus.o_instr_valid), 32'd1);
        check("stall_head_pc", bus.o_pc, RESET_PC);
        cap.delete();
        bus.i_instr_ready = 1'b1;
        wait_cap(4, 60, "stall_release_timeout");
        check("stall_release_pc0", cap[0].pc, 32'h0);
        check("stall_release_pc3", cap[3].pc, 32'hC);

        // Redirect with two requests in flight at 3-cycle latency.
        lat = 3;
        begin
            int k = 0;
            while (mq.size() != 2 && k < 50) begin
                tick(1);
                k++;
            end
        end
        check("two_inflight", 32'(mq.size()), 32'd2);
        redirect_to(32'h100);
        cap.delete();
        issued_q.delete();
        wait_cap(2, 60, "redirect_timeout");
        check("redirect_pc0", cap[0].pc, 32'h100);
        check("redirect_pc1", cap[1].pc, 32'h104);
        check("redirect_issue0", issued_q[0], 32'h100);

        // Memory ready toggling with 3-cycle latency.
        mem_toggle = 1'b1;
        cap.delete();
        tick(80);
        mem_toggle = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        check("toggle_progress", 32'(cap.size() >= 8), 32'd1);

        // Back-to-back redirects: discards accumulate, only the last target wins.
        redirect_to(32'h300);
        redirect_to(32'h400);
        cap.delete();
        issued_q.delete();
        wait_cap(3, 80, "double_redirect_timeout");
        check("double_redirect_pc0", cap[0].pc, 32'h400);
        check("double_redirect_issue0", issued_q[0], 32'h400);

        // Reset in the middle of traffic.
        rst_n = 1'b1;
        tick(1);
        check_zero_outputs("midreset");
        rst_n = 1'b0;
        cap.delete();
        wait_cap(2, 60, "midreset_timeout");
        check("midreset_pc0", cap[0].pc, RESET_PC);
        check("midreset_pc1", cap[1].pc, RESET_PC + 32'd4);

        // Misaligned redirect target.
        lat = 1;
        redirect_to(32'h102);
        issued_q.delete();
        cap.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_flag", 32'(bus.o_misaligned), 32'd1);
        check("misalign_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        tick(10);
        check("misalign_flag_sticky", 32'(bus.o_misaligned), 32'd1);
        check("misalign_halt_req", 32'(bus.o_imem_req_valid), 32'd0);
        check("misalign_halt_instr", 32'(bus.o_instr_valid), 32'd0);
        check("misalign_no_issue", 32'(issued_q.size()), 32'd0);
        check("misalign_no_deliver", 32'(cap.size()), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("misalign_cleared", 32'(bus.o_misaligned), 32'd0);
        rst_n = 1'b0;
        tick(1);
`else
        check("misalign_flag_off", 32'(bus.o_misaligned), 32'd0);
        wait_cap(2, 40, "align_timeout");
        check("align_pc0", cap[0].pc, 32'h100);
        check("align_issue0", issued_q[0], 32'h100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
